// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the sequential ALU and the
// execute-stage result mux.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'd0;
  localparam logic [3:0] ALU_OR    = 4'd1;
  localparam logic [3:0] ALU_ADD   = 4'd2;
  localparam logic [3:0] ALU_SUB   = 4'd3;
  localparam logic [3:0] ALU_SLT   = 4'd4;
  localparam logic [3:0] ALU_SGE   = 4'd5;
  localparam logic [3:0] ALU_EQ    = 4'd6;
  localparam logic [3:0] ALU_XOR   = 4'd7;
  localparam logic [3:0] ALU_SLL   = 4'd8;
  localparam logic [3:0] ALU_SRL   = 4'd9;
  localparam logic [3:0] ALU_SRA   = 4'd10;
  localparam logic [3:0] ALU_SLTU  = 4'd11;
  localparam logic [3:0] ALU_MUL   = 4'd12;
  localparam logic [3:0] ALU_MULHU = 4'd13;
  localparam logic [3:0] ALU_DIVU  = 4'd14;
  localparam logic [3:0] ALU_REMU  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } alu_state_e;

  // Codes 12-15 share the iterative unit; bit 1 picks divide, bit 0 the upper half.
  function automatic logic isMulDiv(input logic [3:0] op);
    return op[3] & op[2];
  endfunction

  function automatic logic isDiv(input logic [3:0] op);
    return op[1];
  endfunction

  function automatic logic selHigh(input logic [3:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier and restoring divider, one bit per clock.
// The accumulator holds {high/remainder, low/quotient} in both modes.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             div_i,
  input  logic             selHi_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] res_o
);

  localparam int CW = $clog2(WIDTH);

  logic                 busy_q, busy_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 div_q, div_d;
  logic                 selHi_q, selHi_d;
  logic [2*WIDTH-1:0]   step;
  logic [WIDTH:0]       mulSum;
  logic [WIDTH:0]       trial;

  assign done_o = busy_q && (count_q == CW'(WIDTH - 1));
  // The result is taken from the final step so it can be registered on the last edge.
  assign res_o  = selHi_q ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0];

  always_comb begin
    mulSum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    trial  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    step   = {mulSum, acc_q[WIDTH-1:1]};
    if (div_q) begin
      // A zero divisor always subtracts, giving all-ones quotient and remainder = dividend.
      if (trial >= {1'b0, opnd_q}) begin
        step = {trial[WIDTH-1:0] - opnd_q, acc_q[WIDTH-2:0], 1'b1};
      end else begin
        step = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    busy_d  = busy_q;
    count_d = count_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    selHi_d = selHi_q;
    if (start_i) begin
      busy_d  = 1'b1;
      count_d = '0;
      opnd_d  = div_i ? b_i : a_i;
      acc_d   = {{WIDTH{1'b0}}, (div_i ? a_i : b_i)};
      div_d   = div_i;
      selHi_d = selHi_i;
    end else if (busy_q) begin
      acc_d   = step;
      count_d = count_q + 1'b1;
      if (done_o) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      count_q <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      selHi_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      selHi_q <= selHi_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: single-cycle logic/arith/shift/compare ops plus
// iterative MUL/MULHU/DIVU/REMU that hold in_ready low while they run.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] aluRes;
  logic [SHW-1:0]   shamt;
  logic             mdStart;
  logic             mdDone;
  logic [WIDTH-1:0] mdRes;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = outValid_q;
  assign result    = result_q;
  assign zero_flag = zero_q;
  assign shamt     = in2[SHW-1:0];

  always_comb begin
    aluRes = '0;
    unique case (alu_control)
      ALU_AND:  aluRes = in1 & in2;
      ALU_OR:   aluRes = in1 | in2;
      ALU_ADD:  aluRes = in1 + in2;
      ALU_SUB:  aluRes = in1 - in2;
      ALU_SLT:  aluRes = {{(WIDTH-1){1'b0}}, ($signed(in1) <  $signed(in2))};
      ALU_SGE:  aluRes = {{(WIDTH-1){1'b0}}, ($signed(in1) >= $signed(in2))};
      ALU_EQ:   aluRes = {{(WIDTH-1){1'b0}}, (in1 == in2)};
      ALU_XOR:  aluRes = in1 ^ in2;
      ALU_SLL:  aluRes = in1 << shamt;
      ALU_SRL:  aluRes = in1 >> shamt;
      ALU_SRA:  aluRes = $unsigned($signed(in1) >>> shamt);
      ALU_SLTU: aluRes = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      default:  aluRes = '0;
    endcase
  end

  alu_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start_i(mdStart),
    .div_i  (isDiv(alu_control)),
    .selHi_i(selHigh(alu_control)),
    .a_i    (in1),
    .b_i    (in2),
    .done_o (mdDone),
    .res_o  (mdRes)
  );

  // Idle accepts every cycle; iterative ops park the FSM until the unit signals done.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    zero_d     = zero_q;
    outValid_d = 1'b0;
    mdStart    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (MULDIV_EN && isMulDiv(alu_control)) begin
            mdStart = 1'b1;
            state_d = isDiv(alu_control) ? ST_DIV : ST_MUL;
          end else begin
            result_d   = aluRes;
            zero_d     = (aluRes == '0);
            outValid_d = 1'b1;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (mdDone) begin
          result_d   = mdRes;
          zero_d     = (mdRes == '0);
          outValid_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      result_q   <= '0;
      zero_q     <= 1'b1;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      outValid_q <= outValid_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed boundary steps plus random ops
// compared against an arithmetic reference model; a second 8-bit instance covers the narrow build.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid, inReady, outValid, zeroFlag;
  logic [31:0] in1, in2, result;
  logic [3:0]  aluCtl;
  logic        inValid8, inReady8, outValid8, zero8;
  logic [7:0]  a8, b8, result8;
  logic [3:0]  ctl8;
  int          nChecks = 0;
  int          nFails  = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32), .MULDIV_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
    .in1(in1), .in2(in2), .alu_control(aluCtl),
    .out_valid(outValid), .result(result), .zero_flag(zeroFlag)
  );

  alu_seq #(.WIDTH(8), .MULDIV_EN(1'b1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(inValid8), .in_ready(inReady8),
    .in1(a8), .in2(b8), .alu_control(ctl8),
    .out_valid(outValid8), .result(result8), .zero_flag(zero8)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model built straight from the opcode table.
  function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    int unsigned sh;
    sh = b % 32;
    p  = 64'(a) * 64'(b);
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a - b;
      4'd4:  return ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
      4'd5:  return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  return (a == b) ? 32'd1 : 32'd0;
      4'd7:  return a ^ b;
      4'd8:  return a << sh;
      4'd9:  return a >> sh;
      4'd10: return 32'($signed(a) >>> sh);
      4'd11: return (a < b) ? 32'd1 : 32'd0;
      4'd12: return p[31:0];
      4'd13: return p[63:32];
      4'd14: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    inValid = v;
    aluCtl  = op;
    in1     = a;
    in2     = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle op: result must be there one edge after acceptance; in_valid is left high.
  task automatic runSingle(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
    applyStimulus(1'b1, op, a, b);
    tick();
    checkOutput($sformatf("%s result", tag), result, exp);
    checkOutput($sformatf("%s out_valid", tag), {31'b0, outValid}, 32'd1);
    checkOutput($sformatf("%s zero_flag", tag), {31'b0, zeroFlag}, {31'b0, (exp == 32'd0)});
  endtask

  // Iterative op: junk is driven on the inputs while busy and must be ignored.
  task automatic runMulti(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    int edges;
    int readyErr;
    applyStimulus(1'b1, op, a, b);
    tick();
    edges    = 1;
    readyErr = 0;
    while (outValid !== 1'b1 && edges < 100) begin
      if (inReady !== 1'b0) readyErr++;
      applyStimulus(1'($urandom), 4'($urandom), $urandom, $urandom);
      tick();
      edges++;
    end
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput($sformatf("%s latency", tag), 32'(edges), 32'd33);
    checkOutput($sformatf("%s busy in_ready", tag), 32'(readyErr), 32'd0);
    checkOutput($sformatf("%s result", tag), result, exp);
    checkOutput($sformatf("%s zero_flag", tag), {31'b0, zeroFlag}, {31'b0, (exp == 32'd0)});
    checkOutput($sformatf("%s in_ready", tag), {31'b0, inReady}, 32'd1);
  endtask

  initial begin
    logic [31:0] exp2 [7];
    logic [3:0]  op;
    logic [31:0] a, b;
    int          edges;
    int          pulses;
    exp2 = '{32'd2, 32'd3, 32'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0};

    rst = 1'b1;
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
    inValid8 = 1'b0; ctl8 = 4'd0; a8 = 8'd0; b8 = 8'd0;
    tick();
    tick();
    checkOutput("reset in_ready", {31'b0, inReady}, 32'd1);
    checkOutput("reset out_valid", {31'b0, outValid}, 32'd0);
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset zero_flag", {31'b0, zeroFlag}, 32'd1);
    rst = 1'b0;

    for (int k = 0; k < 7; k++) begin
      runSingle($sformatf("b2b op%0d", k), 4'(k), 32'd2, 32'd3, exp2[k]);
    end
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    checkOutput("idle out_valid", {31'b0, outValid}, 32'd0);

    runSingle("sra", 4'd10, 32'h8000_0000, 32'd4, 32'hF800_0000);
    runSingle("srl", 4'd9, 32'h8000_0000, 32'd4, 32'h0800_0000);
    runSingle("sll", 4'd8, 32'h8000_0000, 32'd4, 32'h0000_0000);
    runSingle("slt minneg", 4'd4, 32'h8000_0000, 32'd0, 32'd1);
    runSingle("sltu minneg", 4'd11, 32'h8000_0000, 32'd0, 32'd0);
    runSingle("sll by 0", 4'd8, 32'h8000_0001, 32'd0, 32'h8000_0001);
    runSingle("srl upper ignored", 4'd9, 32'h8000_0000, 32'h0000_0121, 32'h4000_0000);
    runSingle("sra by 31", 4'd10, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
    runSingle("sub wrap", 4'd3, 32'd0, 32'd1, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);

    runMulti("mul", 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    tick();
    checkOutput("mul pulse ends", {31'b0, outValid}, 32'd0);
    checkOutput("mul result held", result, 32'd1);
    runMulti("mulhu", 4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    runMulti("divu", 4'd14, 32'd100, 32'd7, 32'd14);
    runMulti("remu", 4'd15, 32'd100, 32'd7, 32'd2);
    runMulti("divu by 0", 4'd14, 32'd12345, 32'd0, 32'hFFFF_FFFF);
    runMulti("remu by 0", 4'd15, 32'd9, 32'd0, 32'd9);

    // Reset in the middle of a divide, with a competing in_valid.
    runSingle("pre-reset add", 4'd2, 32'd2, 32'd3, 32'd5);
    applyStimulus(1'b1, 4'd14, 32'd100, 32'd7);
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
    repeat (5) tick();
    rst = 1'b1;
    applyStimulus(1'b1, 4'd2, 32'd1, 32'd1);
    tick();
    tick();
    checkOutput("abort in_ready", {31'b0, inReady}, 32'd1);
    checkOutput("abort out_valid", {31'b0, outValid}, 32'd0);
    checkOutput("abort result", result, 32'd0);
    checkOutput("abort zero_flag", {31'b0, zeroFlag}, 32'd1);
    rst = 1'b0;
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
    pulses = 0;
    repeat (40) begin
      tick();
      if (outValid === 1'b1) pulses++;
    end
    checkOutput("no late out_valid", 32'(pulses), 32'd0);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 11));
      a  = $urandom;
      b  = (i % 4 == 0) ? a : $urandom;
      runSingle($sformatf("rand op%0d", op), op, a, b, refAlu(op, a, b));
    end
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(12, 15));
      a  = $urandom;
      b  = (i % 4 == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000)));
      runMulti($sformatf("rand md op%0d", op), op, a, b, refAlu(op, a, b));
    end

    // Narrow build: 8-bit MUL latency 9 and back-to-back acceptance in the out_valid cycle.
    inValid8 = 1'b1; ctl8 = 4'd12; a8 = 8'h10; b8 = 8'h10;
    tick();
    inValid8 = 1'b0;
    edges = 1;
    while (outValid8 !== 1'b1 && edges < 50) begin
      tick();
      edges++;
    end
    checkOutput("w8 mul latency", 32'(edges), 32'd9);
    checkOutput("w8 mul result", {24'b0, result8}, 32'h00);
    checkOutput("w8 mul zero_flag", {31'b0, zero8}, 32'd1);
    checkOutput("w8 in_ready", {31'b0, inReady8}, 32'd1);
    inValid8 = 1'b1; ctl8 = 4'd2; a8 = 8'd3; b8 = 8'd4;
    tick();
    inValid8 = 1'b0;
    checkOutput("w8 next op valid", {31'b0, outValid8}, 32'd1);
    checkOutput("w8 next op result", {24'b0, result8}, 32'd7);
    inValid8 = 1'b1; ctl8 = 4'd13; a8 = 8'h10; b8 = 8'h10;
    tick();
    inValid8 = 1'b0;
    edges = 1;
    while (outValid8 !== 1'b1 && edges < 50) begin
      tick();
      edges++;
    end
    checkOutput("w8 mulhu latency", 32'(edges), 32'd9);
    checkOutput("w8 mulhu result", {24'b0, result8}, 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
